// File: rtl/ca_pkg.sv
// Shared types and constants for the chromatic-adaptation frame scheduler.
// The matrix is nine row-major Q16.16 elements, with element k at bits [32k+31:32k].
package ca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_WRITE    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam int MTX_W      = 288;
  localparam int MTX_ELEM_W = 32;
  localparam int Q_FRAC     = 16;

  localparam logic [23:0]           ERR_PIXEL_DEF = 24'hFF0000;
  localparam logic [MTX_ELEM_W-1:0] Q_ONE         = 32'h00010000;
  localparam logic [MTX_W-1:0]      IDENTITY_MTX  = {Q_ONE, 96'h0, Q_ONE, 96'h0, Q_ONE};

  // Builds a diagonal matrix from its three diagonal elements.
  function automatic logic [MTX_W-1:0] diag_mtx(input logic [31:0] d0,
                                                input logic [31:0] d1,
                                                input logic [31:0] d2);
    return {d2, 96'h0, d1, 96'h0, d0};
  endfunction

endpackage

// File: rtl/ca_watchdog.sv
// Loadable down-counter that watches one handshake wait.
// expire is raised on the LOAD_VAL-th enabled cycle after a load.
module ca_watchdog #(
  parameter int CNT_W    = 10,
  parameter int LOAD_VAL = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  // Down-counter; a load takes priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL - 1);
    end else if (en && (cnt != {CNT_W{1'b0}})) begin
      cnt <= cnt - CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign expire = en && (cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/ca_frame_scheduler.sv
// Walks one frame of pixels through image_processor, one pixel in flight at a time,
// and owns the compensation matrix, which only changes at frame start.
module ca_frame_scheduler
  import ca_pkg::*;
#(
  parameter int          IMG_W     = 4,
  parameter int          IMG_H     = 4,
  parameter int          ADDR_W    = 4,
  parameter int          TIMEOUT   = 1000,
  parameter logic [23:0] ERR_PIXEL = ERR_PIXEL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [287:0]      mtx_in,
  input  logic              mtx_load,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [23:0]       src_rdata,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [23:0]       dst_wdata,
  output logic [287:0]      comp_matrix,
  output logic              matrix_valid,
  output logic [23:0]       proc_in_rgb,
  output logic              proc_in_valid,
  input  logic              proc_in_ready,
  input  logic [23:0]       proc_out_rgb,
  input  logic              proc_out_valid,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_W * IMG_H - 1);
  localparam int                WD_W     = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   index;
  logic [MTX_W-1:0]    pend_mtx;
  logic                pend_valid;
  logic                start_ok, wd_expire, send_to, wait_to;

  // A load in the same cycle as start also counts as a usable matrix.
  assign start_ok = start && (matrix_valid || pend_valid || mtx_load);
  assign send_to  = (state == ST_SEND) && !proc_in_ready && wd_expire;
  assign wait_to  = (state == ST_WAIT_OUT) && !proc_out_valid && wd_expire;

  ca_watchdog #(
    .CNT_W   (WD_W),
    .LOAD_VAL(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .load  ((state == ST_LOAD) || ((state == ST_SEND) && proc_in_ready)),
    .en    ((state == ST_SEND) || (state == ST_WAIT_OUT)),
    .expire(wd_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = start_ok ? ST_FETCH : ST_IDLE;
      ST_FETCH:    state_nxt = ST_LOAD;
      ST_LOAD:     state_nxt = ST_SEND;
      ST_SEND: begin
        if (proc_in_ready) begin
          state_nxt = ST_WAIT_OUT;
        end else if (wd_expire) begin
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_SEND;
        end
      end
      ST_WAIT_OUT: state_nxt = (proc_out_valid || wd_expire) ? ST_WRITE : ST_WAIT_OUT;
      ST_WRITE:    state_nxt = (index == LAST_IDX) ? ST_DONE : ST_FETCH;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    src_rd_en     = 1'b0;
    src_addr      = {ADDR_W{1'b0}};
    proc_in_valid = 1'b0;
    dst_wr_en     = 1'b0;
    dst_addr      = {ADDR_W{1'b0}};
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
      end
      ST_FETCH: begin
        src_rd_en = 1'b1;
        src_addr  = index;
        busy      = 1'b1;
      end
      ST_LOAD:     busy = 1'b1;
      ST_SEND: begin
        proc_in_valid = 1'b1;
        busy          = 1'b1;
      end
      ST_WAIT_OUT: busy = 1'b1;
      ST_WRITE: begin
        dst_wr_en = 1'b1;
        dst_addr  = index;
        busy      = 1'b1;
      end
      ST_DONE:     done = 1'b1;
      default: begin
      end
    endcase
  end

  // Matrix shadowing, pixel datapath, index and error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mtx     <= {MTX_W{1'b0}};
      pend_valid   <= 1'b0;
      comp_matrix  <= {MTX_W{1'b0}};
      matrix_valid <= 1'b0;
      index        <= {ADDR_W{1'b0}};
      proc_in_rgb  <= 24'h0;
      dst_wdata    <= 24'h0;
      err_count    <= 8'd0;
    end else begin
      if (mtx_load) begin
        pend_mtx <= mtx_in;
      end
      if ((state == ST_IDLE) && start_ok) begin
        pend_valid   <= 1'b0;
        matrix_valid <= 1'b1;
        if (mtx_load) begin
          comp_matrix <= mtx_in;
        end else if (pend_valid) begin
          comp_matrix <= pend_mtx;
        end
        err_count <= 8'd0;
        index     <= {ADDR_W{1'b0}};
      end else if (mtx_load) begin
        pend_valid <= 1'b1;
      end
      if (state == ST_LOAD) begin
        proc_in_rgb <= src_rdata;
      end
      if ((state == ST_WAIT_OUT) && proc_out_valid) begin
        dst_wdata <= proc_out_rgb;
      end else if (send_to || wait_to) begin
        dst_wdata <= ERR_PIXEL;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
      if ((state == ST_WRITE) && (index != LAST_IDX)) begin
        index <= index + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ca_frame_scheduler.sv
// Randomized scoreboard bench: the stimulus side queues expected destination writes,
// and a monitor compares them against the DUT's write strobes.
module tb_ca_frame_scheduler;
  import ca_pkg::*;

  localparam int NPIX = 16;
  localparam int TO   = 1000;

  logic         clk = 1'b0;
  logic         rst_n, start, mtx_load, src_rd_en, dst_wr_en, matrix_valid;
  logic         proc_in_valid, proc_in_ready, proc_out_valid, busy, done;
  logic [287:0] mtx_in, comp_matrix;
  logic [3:0]   src_addr, dst_addr;
  logic [23:0]  src_rdata, dst_wdata, proc_in_rgb, proc_out_rgb;
  logic [7:0]   err_count;

  always #5 clk = ~clk;

  ca_frame_scheduler #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .TIMEOUT(TO), .ERR_PIXEL(24'hFF0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mtx_in(mtx_in), .mtx_load(mtx_load),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .comp_matrix(comp_matrix), .matrix_valid(matrix_valid),
    .proc_in_rgb(proc_in_rgb), .proc_in_valid(proc_in_valid), .proc_in_ready(proc_in_ready),
    .proc_out_rgb(proc_out_rgb), .proc_out_valid(proc_out_valid),
    .busy(busy), .done(done), .err_count(err_count)
  );

  typedef struct packed {
    logic [3:0]  addr;
    logic [23:0] data;
  } wr_t;

  int           checks = 0, errors = 0;
  wr_t          exp_q[$];
  logic [287:0] frame_mtx_exp = '0;
  int           exp_err = 0;
  logic [23:0]  src_mem[NPIX];
  int           stall_cfg[NPIX];
  bit           drop_cfg[NPIX];
  int           done_seen = 0, rd_cnt = 0, wr_cnt = 0;
  logic [287:0] tb_pend = '0, tb_active = '0;
  bit           tb_pend_v = 1'b0;
  int           p = 0;
  logic [287:0] warm;

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Source RAM: data for a read strobe appears one cycle later, otherwise junk.
  initial begin
    logic [3:0] ra;
    bit         rn;
    src_rdata = 24'h0;
    forever begin
      @(negedge clk);
      rn = src_rd_en;
      ra = src_addr;
      @(posedge clk);
      #1 src_rdata = rn ? src_mem[ra] : 24'($urandom);
    end
  end

  // Behavioural processor: configurable ready stall, echo after 3 cycles, optional drop.
  initial begin
    bit          in_ep;
    int          stall_left, xfers, out_cnt, sc;
    logic [23:0] ep_rgb, out_data;
    proc_in_ready = 1'b0; proc_out_valid = 1'b0; proc_out_rgb = 24'h0;
    in_ep = 1'b0; out_cnt = 0; stall_left = 0; xfers = 0; ep_rgb = '0; out_data = '0;
    forever begin
      @(negedge clk);
      proc_out_valid = 1'b0;
      sc = (p < NPIX) ? stall_cfg[p] : 0;
      if (!rst_n) begin
        out_cnt = 0; in_ep = 1'b0; proc_in_ready = 1'b0;
      end else begin
        if (out_cnt > 0) begin
          out_cnt--;
          if (out_cnt == 0) begin
            proc_out_valid = 1'b1;
            proc_out_rgb   = out_data;
          end
        end
        if (proc_in_valid) begin
          if (!in_ep) begin
            in_ep = 1'b1; stall_left = sc; xfers = 0; ep_rgb = proc_in_rgb;
          end else if (sc <= 16) begin
            check("in_rgb_stable", proc_in_rgb, ep_rgb);
          end
          if (stall_left > 0) begin
            stall_left--;
            proc_in_ready = 1'b0;
            // Stray output pulses while the pixel is still being offered must be ignored.
            if ($urandom_range(0, 3) == 0 && out_cnt == 0) begin
              proc_out_valid = 1'b1;
              proc_out_rgb   = 24'($urandom);
            end
          end else begin
            proc_in_ready = 1'b1;
            xfers++;
            if (!(p < NPIX && drop_cfg[p])) begin
              out_cnt  = 3;
              out_data = proc_in_rgb;
            end
          end
        end else begin
          proc_in_ready = 1'($urandom_range(0, 1));
          if (in_ep) begin
            in_ep = 1'b0;
            check("xfer_count", xfers, (sc >= TO) ? 0 : 1);
            p++;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every destination write and checks frame end.
  initial begin
    bit  prev_done;
    wr_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_cycle", done, 0);
      prev_done = done;
      if (src_rd_en) begin
        rd_cnt++;
        check("mtx_at_fetch", comp_matrix, frame_mtx_exp);
      end
      if (dst_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h", dst_addr, dst_wdata);
        end else begin
          e = exp_q.pop_front();
          check("dst_addr", dst_addr, e.addr);
          check("dst_data", dst_wdata, e.data);
          check("mtx_stable", comp_matrix, frame_mtx_exp);
        end
      end
      if (done) begin
        done_seen++;
        check("err_count", err_count, exp_err);
        check("matrix_valid", matrix_valid, 1);
        check("pixels_left", exp_q.size(), 0);
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_frame(input bit ramp);
    for (int i = 0; i < NPIX; i++) begin
      src_mem[i]   = ramp ? {8'(16 * i), 8'(i), 8'(8'h5A ^ 8'(i))} : 24'($urandom);
      stall_cfg[i] = $urandom_range(0, 2);
      drop_cfg[i]  = 1'b0;
    end
  endtask

  task automatic load_mtx(input logic [287:0] m);
    mtx_in = m; mtx_load = 1'b1;
    tb_pend = m; tb_pend_v = 1'b1;
    tick(1);
    mtx_load = 1'b0;
  endtask

  // Queues what the frame must produce: echo, or the error pixel when a wait times out.
  task automatic launch(input bit ld, input logic [287:0] m);
    wr_t w;
    int  errs;
    errs = 0;
    p = 0;
    for (int i = 0; i < NPIX; i++) begin
      w.addr = 4'(i);
      if (drop_cfg[i] || stall_cfg[i] >= TO) begin
        w.data = 24'hFF0000;
        errs++;
      end else begin
        w.data = src_mem[i];
      end
      exp_q.push_back(w);
    end
    exp_err = errs;
    if (ld) tb_active = m;
    else if (tb_pend_v) tb_active = tb_pend;
    tb_pend_v = 1'b0;
    frame_mtx_exp = tb_active;
    start = 1'b1;
    if (ld) begin
      mtx_in = m; mtx_load = 1'b1;
    end
    tick(1);
    start = 1'b0; mtx_load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n, d0;
    n = 0; d0 = done_seen;
    while (done_seen == d0 && n < 6000) begin
      tick(1);
      n++;
    end
    if (done_seen == d0) begin
      checks++; errors++;
      $display("FAIL %s no done pulse within %0d cycles", name, n);
    end
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 3000) begin
      tick(1);
      n++;
    end
    if (wr_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_writes actual=%0d required=%0d", wr_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {src_rd_en, src_addr, dst_wr_en, dst_addr, dst_wdata, matrix_valid,
                 proc_in_rgb, proc_in_valid, busy, done, err_count}, 0);
    check({name, "_mtx"}, comp_matrix, 0);
  endtask

  initial begin
    int d, r0;
    warm = diag_mtx(32'h00011999, 32'h00010CCC, 32'h0000E666);
    rst_n = 1'b0; start = 1'b0; mtx_load = 1'b0; mtx_in = '0;
    for (int i = 0; i < NPIX; i++) begin
      src_mem[i] = '0; stall_cfg[i] = 0; drop_cfg[i] = 1'b0;
    end
    tick(2);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick(2);

    // Start with no matrix ever loaded.
    start = 1'b1; tick(1); start = 1'b0;
    tick(8);
    check("no_mtx_rd", rd_cnt, 0);
    check("no_mtx_busy", busy, 0);

    // Frame A: identity loaded with start, ramp source, long stall on pixel 5.
    cfg_frame(1'b1);
    stall_cfg[5] = 10;
    launch(1'b1, IDENTITY_MTX);
    wait_writes(3);
    load_mtx(warm);
    start = 1'b1; tick(1); start = 1'b0;
    wait_done("frame_a");
    d = done_seen;
    tick(20);
    check("single_done", done_seen, d);
    check("idle_after_a", busy, 0);
    check("mtx_after_a", comp_matrix, IDENTITY_MTX);

    // Frame B: pending warm matrix takes effect, pixel 2 output dropped.
    cfg_frame(1'b0);
    drop_cfg[2] = 1'b1;
    launch(1'b0, '0);
    wait_done("frame_b");

    // Frame C: ready never arrives for pixel 1; pixel 6 is granted on the last allowed cycle.
    cfg_frame(1'b0);
    stall_cfg[1] = TO;
    stall_cfg[6] = TO - 1;
    launch(1'b0, '0);
    wait_done("frame_c");

    // Frame D: reset at pixel 7, then a fresh frame from pixel 0.
    cfg_frame(1'b0);
    launch(1'b0, '0);
    wait_writes(wr_cnt + 7);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    tb_pend_v = 1'b0; tb_active = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    r0 = rd_cnt;
    start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    check("no_mtx_after_reset", rd_cnt, r0);
    cfg_frame(1'b0);
    launch(1'b1, IDENTITY_MTX);
    wait_done("frame_d");
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca_frame_scheduler.md
Name: ca_frame_scheduler

Overview:
- Sequences one frame of pixels through the chromatic-adaptation `image_processor`.
- Reads pixels from a source pixel RAM, drives the processor's valid/ready input handshake and waits for `output_valid`. Writes each result to a destination RAM.
- Owns the 3x3 Q16.16 compensation matrix: new matrices are shadowed and applied only at frame start.
- Sits between the frame buffers and `image_processor`; replaces testbench-style per-pixel sequencing in the full design.

Parameters:
- IMG_W, 4, frame width in pixels
- IMG_H, 4, frame height in pixels
- ADDR_W, 4, pixel address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
- TIMEOUT, 1000, max cycles waited for `proc_input_ready` or for `proc_output_valid`
- ERR_PIXEL, 24'hFF0000, value written on timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start one frame pass; sampled in IDLE only
- mtx_in  in  288  new matrix, 9x32 Q16.16, element k at [32k+31:32k], row-major
- mtx_load  in  1  latch mtx_in into the pending register
- src_rd_en  out  1  source RAM read strobe
- src_addr  out  ADDR_W  source pixel address
- src_rdata  in  24  source pixel, valid 1 cycle after src_rd_en
- dst_wr_en  out  1  destination write strobe
- dst_addr  out  ADDR_W  destination address
- dst_wdata  out  24  destination pixel
- comp_matrix  out  288  active matrix to processor
- matrix_valid  out  1  active matrix loaded
- proc_in_rgb  out  24  pixel to processor
- proc_in_valid  out  1  pixel valid
- proc_in_ready  in  1  processor ready
- proc_out_rgb  in  24  processed pixel
- proc_out_valid  in  1  processed pixel valid
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- err_count  out  8  saturating timeout count for the last/current frame

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0, comp_matrix is 0, matrix_valid=0.
  - Pending matrix and its pending flag are cleared; state=IDLE.
  - A reset mid-frame abandons the frame without writing further pixels.
- Matrix handling:
  - `mtx_load` in any state writes the pending register and sets the pending flag; the last load wins.
  - The active matrix never changes mid-frame.
- State IDLE:
  - On `start`=1 with (matrix_valid or pending flag set):
    - If pending, copy pending to comp_matrix, set matrix_valid=1 and clear pending.
    - A `mtx_load` in the same cycle as `start` is the matrix used.
    - Clear err_count, set pixel index=0 and busy=1, then go to FETCH.
  - `start` with no matrix ever loaded is ignored.
- Frame pass states:
  - FETCH: src_rd_en=1 for 1 cycle, src_addr=index, then go to LOAD.
  - LOAD: register src_rdata into proc_in_rgb, then go to SEND.
  - SEND:
    - proc_in_valid=1 and proc_in_rgb held stable until a cycle with proc_in_ready=1; that cycle is the transfer.
    - Then drop valid and go to WAIT_OUT.
    - If ready has not been seen after TIMEOUT cycles, drop valid, write ERR_PIXEL, increment err_count and go to WRITE.
  - WAIT_OUT:
    - On proc_out_valid=1, capture proc_out_rgb into dst_wdata and go to WRITE.
    - After TIMEOUT cycles without it, use ERR_PIXEL, increment err_count and go to WRITE.
    - proc_out_valid seen outside WAIT_OUT is ignored.
  - WRITE: dst_wr_en=1 for 1 cycle, dst_addr=index.
    - If index==IMG_W*IMG_H-1, go to DONE.
    - Otherwise index+1, then FETCH.
  - DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Counters and timing:
  - The watchdog counter resets on every SEND/WAIT_OUT entry.
  - err_count saturates at 255.
  - Best-case per-pixel latency is 4 cycles plus the processor latency.
  - At most one pixel is in flight; raster order, address = y*IMG_W + x.
- `start` while busy is ignored.

Decomposition:
- Package `ca_pkg`:
  - state enum
  - MTX_W=288, MTX_ELEM_W=32, Q_FRAC=16
  - ERR_PIXEL default
  - identity matrix constant (elements 32'h00010000)
- One sub-module, `ca_watchdog`:
  - loadable down-counter with clear, enable and expire outputs
  - instanced once and shared by SEND and WAIT_OUT

Test Plan:
1. Identity load and start with a 4x4 ramp source and a behavioural 3-cycle processor echo → dst holds the same 16 pixels, done pulses once, err_count=0, matrix_valid=1.
2. Warm matrix (diag 00011999/00010CCC/0000E666) loaded during a frame → comp_matrix stays identity until done; the next start shows the warm matrix from the first FETCH cycle.
3. Processor holds proc_in_ready=0 for 10 cycles on pixel 5 → proc_in_valid and proc_in_rgb stay stable all 10 cycles; exactly one transfer.
4. Processor drops the output for pixel 2 → dst[2]=FF0000 after 1000 cycles, err_count=1, remaining pixels correct.
5. Start with no matrix ever loaded → no src_rd_en, busy stays 0. Start while busy → ignored, only one done pulse.
6. rst_n low at pixel 7 → all outputs and matrix_valid are 0 immediately; a new load+start processes from pixel 0.
